// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: Avalon-MM key conditioner producing debounced, maskable, W1C edge interrupts.
// Define KEY_IRQ_CTRL_DEBOUNCE_EN to build the per-key debounce FSMs; otherwise deb follows sync.
module key_irq_ctrl #(
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [KEY_W-1:0] in_port,
  output logic             irq
);

  if (KEY_W < 1 || KEY_W > 32 || DEBOUNCE_CYCLES < 2 || CNT_W < 1 ||
      (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("key_irq_ctrl: invalid parameter combination");
  end

  logic [KEY_W-1:0] meta_q, meta_d;
  logic [KEY_W-1:0] sync_q, sync_d;
  logic [KEY_W-1:0] deb_q, deb_d;
  logic [KEY_W-1:0] edge_sel_q, edge_sel_d;
  logic [KEY_W-1:0] mask_q, mask_d;
  logic [KEY_W-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [KEY_W-1:0] evt_s, cap_set_s, wdata_s;
  logic             wr_s;
  logic             unused_wdata_s;

  // Two-stage synchronizer; in_port is asynchronous to clk.
  always_comb begin
    meta_d = in_port;
    sync_d = meta_q;
  end

`ifdef KEY_IRQ_CTRL_DEBOUNCE_EN
  typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} deb_state_e;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_e       state_q [KEY_W];
  deb_state_e       state_d [KEY_W];
  logic [CNT_W-1:0] cnt_q   [KEY_W];
  logic [CNT_W-1:0] cnt_d   [KEY_W];

  // Per-key debounce: sync must differ from deb for DEBOUNCE_CYCLES clocks before deb follows.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < KEY_W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync_q[i] != deb_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i]   = {CNT_W{1'b0}};
          end
        end
        ST_COUNT: begin
          if (sync_q[i] == deb_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i]   = sync_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end
`else
  // Debounce disabled: deb simply tracks the synchronized level.
  always_comb begin
    deb_d = sync_q;
  end
`endif

  // Event capture and register writes; a capture on the same edge as a W1C wins.
  always_comb begin
    wr_s           = chipselect & ~write_n;
    wdata_s        = writedata[KEY_W-1:0];
    unused_wdata_s = ^writedata;
    evt_s          = deb_d ^ deb_q;
    // Press lands deb at 0 (sel 0); release lands deb at 1 (sel 1).
    cap_set_s      = evt_s & ~(deb_d ^ edge_sel_q);
    edge_sel_d     = edge_sel_q;
    mask_d         = mask_q;
    edge_cap_d     = edge_cap_q;
    if (wr_s && address == 2'd1) begin
      edge_sel_d = wdata_s;
    end else begin
      edge_sel_d = edge_sel_q;
    end
    if (wr_s && address == 2'd2) begin
      mask_d = wdata_s;
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && address == 2'd3) begin
      edge_cap_d = edge_cap_q & ~wdata_s;
    end else begin
      edge_cap_d = edge_cap_q;
    end
    edge_cap_d = edge_cap_d | cap_set_s;
  end

  // Read mux, registered every clock regardless of chipselect.
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (address)
      2'd0:    readdata_d[KEY_W-1:0] = deb_q;
      2'd1:    readdata_d[KEY_W-1:0] = edge_sel_q;
      2'd2:    readdata_d[KEY_W-1:0] = mask_q;
      2'd3:    readdata_d[KEY_W-1:0] = edge_cap_q;
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  // State registers with synchronous active-low reset; keys reset to released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q     <= {KEY_W{1'b1}};
      sync_q     <= {KEY_W{1'b1}};
      deb_q      <= {KEY_W{1'b1}};
      edge_sel_q <= {KEY_W{1'b0}};
      mask_q     <= {KEY_W{1'b0}};
      edge_cap_q <= {KEY_W{1'b0}};
      readdata_q <= 32'h0000_0000;
`ifdef KEY_IRQ_CTRL_DEBOUNCE_EN
      for (int i = 0; i < KEY_W; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
`endif
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      edge_sel_q <= edge_sel_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
`ifdef KEY_IRQ_CTRL_DEBOUNCE_EN
      for (int i = 0; i < KEY_W; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
`endif
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & mask_q);

endmodule

// File: doc/key_irq_ctrl.md
# key_irq_ctrl

Avalon-MM slave that conditions up to KEY_W raw board key inputs and turns them into maskable, software-clearable interrupts for the Nios II. Each key gets a two-flop synchronizer and a per-key debounce state machine. Confirmed press or release events are latched into a write-1-to-clear edge-capture register. A single level `irq` goes to the Qsys interrupt receiver in place of a bare PIO key interrupt.

## Interface
Parameters:
- KEY_W, 4 — number of key inputs (1..32).
- DEBOUNCE_CYCLES, 1000000 — clocks an input must stay stable before it is accepted (20 ms at 50 MHz); minimum 2.
- CNT_W, 20 — debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; registered.
- in_port  in  KEY_W  raw key levels, active-low (0 = pressed); asynchronous to clk.
- irq  out  1  interrupt request, active-high level.

## Operation
- Register map (word addresses):
  - 0 STATE (RO): debounced key levels in [KEY_W-1:0].
  - 1 EDGE_SEL (RW): per key, 0 = capture press (1→0), 1 = capture release (0→1).
  - 2 MASK (RW): per-key interrupt enable.
  - 3 EDGE_CAP (R/W1C): latched events; writing 1 clears a bit, writing 0 has no effect.
- Unused upper readdata bits read 0. Writes to address 0 are ignored.
- Synchronizer: two flops per key; `sync` is the second stage.
- Per-key FSM, two states:
  - STABLE: cnt = 0. Stays while sync == deb; moves to COUNT with cnt ← 1 when sync != deb.
  - COUNT: returns to STABLE with cnt ← 0 if sync == deb, which rejects glitches.
  - COUNT: if sync != deb and cnt == DEBOUNCE_CYCLES-1, then deb ← sync, cnt ← 0, STABLE, and the key raises an event. Otherwise cnt ← cnt+1.
- An event sets EDGE_CAP[i] on the same edge that deb changes, but only if the transition direction matches EDGE_SEL[i].
- If an event and a W1C of the same bit land on the same edge, set wins.
- Changing EDGE_SEL affects only later events; it never sets or clears EDGE_CAP.
- irq = |(EDGE_CAP & MASK), combinational from registers. It stays high until software clears the bit or masks it.
- Reset values:
  - sync and deb all ones (released); all FSMs STABLE; cnt 0.
  - EDGE_SEL, MASK, EDGE_CAP all 0; readdata 0; irq 0.
- Reset asserted mid-count discards the count. A key held low through reset produces a press event DEBOUNCE_CYCLES+2 clocks after reset release.

## Timing
- Write takes effect on the clk edge where chipselect=1 and write_n=0. Register value is visible the following cycle.
- Read latency is 1 clock: readdata reflects the address presented on the previous edge and updates every cycle, as with the PIO.
- Debounce latency, with in_port changing just before edge E0 and then held:
  - sync changes after E1.
  - deb, EDGE_CAP and irq change after edge E(DEBOUNCE_CYCLES+1).
- A pulse on sync shorter than DEBOUNCE_CYCLES clocks produces no change.
- Keys are fully independent. Simultaneous events on several keys all latch on the same edge.

## Configuration
- Macro KEY_IRQ_CTRL_DEBOUNCE_EN:
  - Defined: per-key debounce FSM and counters as above.
  - Not defined: FSMs and counters are not built; deb ← sync every clock, and events fire on any sync change. Latency is in_port change before E0 → deb/EDGE_CAP/irq change after E2. DEBOUNCE_CYCLES and CNT_W are ignored.

## Test plan
All scenarios use macro defined, KEY_W=4, DEBOUNCE_CYCLES=4.
- Reset then read addresses 0–3 → 0xF, 0x0, 0x0, 0x0; irq=0.
- Write MASK=0x1. Drive in_port=0xE (key0 held low) before E0 → STATE reads 0xE, EDGE_CAP=0x1 and irq=1 after E5, not before.
- Drive in_port=0xD for 3 clocks, then back to 0xF → STATE stays 0xF, EDGE_CAP stays 0, irq stays 0.
- With EDGE_CAP=0x1, write 0x1 to address 3 on the same edge a key0 press event fires → EDGE_CAP stays 0x1. Then write 0x1 again → EDGE_CAP=0, irq=0 next cycle.
- Write EDGE_SEL=0x2, MASK=0x2. Press then release key1 → no capture on press; EDGE_CAP=0x2 and irq=1 after the release debounces.
- Press key2 and key3 on the same cycle with MASK=0 → EDGE_CAP=0xC and irq=0. Write MASK=0x4 → irq=1 next cycle.
